// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding, default
// parameter values and the counter-width helper.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_DEBOUNCE   = 3'd2,
        ST_READY      = 3'd3,
        ST_FAILED     = 3'd4
    } seq_state_t;

    localparam int DEF_RST_CYCLES    = 64;
    localparam int DEF_LOCK_TIMEOUT  = 50000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int DEF_CNT_W         = 16;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset and lock supervisor: pulses the PLL reset, debounces lock, releases
// the downstream reset and retries or reports failure when lock does not hold.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             restart,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             ready,
    output logic             user_rst,
    output logic             failed,
    output logic [2:0]       state,
    output logic [2:0]       retry_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int HOLD_W = clog2(RST_CYCLES);
    localparam int TMO_W  = clog2(LOCK_TIMEOUT);
    localparam int STAB_W = clog2(STABLE_CYCLES);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [2:0]        RETRY_MAX = 3'(MAX_RETRIES);

    logic              locked_s;
    seq_state_t        cur_state;
    seq_state_t        next_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] next_hold;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [TMO_W-1:0]  next_tmo;
    logic [STAB_W-1:0] stable_cnt;
    logic [STAB_W-1:0] next_stable;
    logic [2:0]        next_retry;
    logic [2:0]        retry_inc;
    logic [CNT_W-1:0]  next_loss;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            cur_state  <= ST_RESET_HOLD;
            hold_cnt   <= '0;
            tmo_cnt    <= '0;
            stable_cnt <= '0;
            retry_cnt  <= '0;
            loss_cnt   <= '0;
            pll_rst    <= 1'b1;
            ready      <= 1'b0;
            user_rst   <= 1'b1;
            failed     <= 1'b0;
        end else begin
            cur_state  <= next_state;
            hold_cnt   <= next_hold;
            tmo_cnt    <= next_tmo;
            stable_cnt <= next_stable;
            retry_cnt  <= next_retry;
            loss_cnt   <= next_loss;
            pll_rst    <= (next_state == ST_RESET_HOLD) || (next_state == ST_FAILED);
            ready      <= (next_state == ST_READY);
            user_rst   <= (next_state != ST_READY);
            failed     <= (next_state == ST_FAILED);
        end
    end

    assign state = cur_state;

    // The timeout covers the whole lock attempt, so a debounce glitch does not
    // buy extra time; restart overrides every other transition at the end.
    always_comb begin
        next_state  = cur_state;
        next_hold   = hold_cnt;
        next_tmo    = tmo_cnt;
        next_stable = stable_cnt;
        next_retry  = retry_cnt;
        next_loss   = loss_cnt;
        retry_inc   = retry_cnt + 3'd1;

        case (cur_state)
            ST_RESET_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    next_state = ST_WAIT_LOCK;
                    next_tmo   = '0;
                end else begin
                    next_hold = hold_cnt + 1'b1;
                end
            end
            ST_WAIT_LOCK, ST_DEBOUNCE: begin
                if (tmo_cnt == TMO_LAST) begin
                    next_retry = retry_inc;
                    next_hold  = '0;
                    next_state = (retry_inc == RETRY_MAX) ? ST_FAILED : ST_RESET_HOLD;
                end else begin
                    next_tmo = tmo_cnt + 1'b1;
                    if (cur_state == ST_WAIT_LOCK) begin
                        if (locked_s) begin
                            next_state  = ST_DEBOUNCE;
                            next_stable = '0;
                        end
                    end else if (!locked_s) begin
                        next_state  = ST_WAIT_LOCK;
                        next_stable = '0;
                    end else if (stable_cnt == STAB_LAST) begin
                        next_state = ST_READY;
                        next_retry = '0;
                    end else begin
                        next_stable = stable_cnt + 1'b1;
                    end
                end
            end
            ST_READY: begin
                if (!locked_s) begin
                    next_state = ST_RESET_HOLD;
                    next_hold  = '0;
                    if (loss_cnt != {CNT_W{1'b1}}) begin
                        next_loss = loss_cnt + 1'b1;
                    end
                end
            end
            ST_FAILED: begin
                next_state = ST_FAILED;
            end
            default: begin
                next_state = ST_RESET_HOLD;
                next_hold  = '0;
            end
        endcase

        if (restart) begin
            next_state = ST_RESET_HOLD;
            next_hold  = '0;
            next_retry = '0;
            next_loss  = loss_cnt;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench: two sequencer instances (default timing and a short
// timeout / narrow loss counter) compared every cycle against a cycle model.
module tb_pll_lock_sequencer;

    localparam int A_RST = 64, A_TMO = 50000, A_STAB = 1024, A_MAXR = 3, A_CW = 16;
    localparam int B_RST = 64, B_TMO = 1000,  B_STAB = 16,   B_MAXR = 3, B_CW = 2;

    localparam int P_A_RST_LOW = 0, P_A_READY = 1, P_A_NOT_READY = 2;
    localparam int P_B_RST_LOW = 3, P_B_READY = 4, P_B_NOT_READY = 5, P_B_DEBOUNCE = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst, a_restart, a_locked;
    logic a_pll_rst, a_ready, a_user_rst, a_failed;
    logic [2:0] a_state, a_retry;
    logic [A_CW-1:0] a_loss;

    logic b_rst, b_restart, b_locked;
    logic b_pll_rst, b_ready, b_user_rst, b_failed;
    logic [2:0] b_state, b_retry;
    logic [B_CW-1:0] b_loss;

    pll_lock_sequencer #(
        .RST_CYCLES(A_RST), .LOCK_TIMEOUT(A_TMO), .STABLE_CYCLES(A_STAB),
        .MAX_RETRIES(A_MAXR), .CNT_W(A_CW)
    ) dut_a (
        .refclk(clk), .rst(a_rst), .restart(a_restart), .pll_locked(a_locked),
        .pll_rst(a_pll_rst), .ready(a_ready), .user_rst(a_user_rst), .failed(a_failed),
        .state(a_state), .retry_cnt(a_retry), .loss_cnt(a_loss)
    );

    pll_lock_sequencer #(
        .RST_CYCLES(B_RST), .LOCK_TIMEOUT(B_TMO), .STABLE_CYCLES(B_STAB),
        .MAX_RETRIES(B_MAXR), .CNT_W(B_CW)
    ) dut_b (
        .refclk(clk), .rst(b_rst), .restart(b_restart), .pll_locked(b_locked),
        .pll_rst(b_pll_rst), .ready(b_ready), .user_rst(b_user_rst), .failed(b_failed),
        .state(b_state), .retry_cnt(b_retry), .loss_cnt(b_loss)
    );

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc++;

    // Model: phase number, cycles spent holding reset, cycles since the PLL
    // reset was released, run of consecutive good lock samples, and the
    // two-sample delay line standing in for the synchroniser.
    typedef struct {
        int phase;
        int hold;
        int since;
        int run;
        int retries;
        int losses;
        bit h1;
        bit h2;
    } mdl_t;

    mdl_t ma, mb;
    bit va = 1'b0, vb = 1'b0;

    function automatic mdl_t model_step(input mdl_t m, input bit r, input bit rs, input bit lk,
                                        input int rstc, input int tmo, input int stab,
                                        input int maxr, input int lossmax);
        mdl_t n;
        bit ls;
        n  = m;
        ls = m.h2;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        n.h2 = m.h1;
        n.h1 = lk;
        if (rs) begin
            n.phase   = 0;
            n.hold    = 0;
            n.retries = 0;
            return n;
        end
        case (m.phase)
            0: begin
                n.hold = m.hold + 1;
                if (n.hold == rstc) begin
                    n.phase = 1;
                    n.since = 0;
                end
            end
            1, 2: begin
                n.since = m.since + 1;
                if (n.since == tmo) begin
                    n.retries = m.retries + 1;
                    n.phase   = (n.retries == maxr) ? 4 : 0;
                    n.hold    = 0;
                end else if (m.phase == 1) begin
                    if (ls) begin
                        n.phase = 2;
                        n.run   = 0;
                    end
                end else if (!ls) begin
                    n.phase = 1;
                end else begin
                    n.run = m.run + 1;
                    if (n.run == stab) begin
                        n.phase   = 3;
                        n.retries = 0;
                    end
                end
            end
            3: begin
                if (!ls) begin
                    n.phase  = 0;
                    n.hold   = 0;
                    n.losses = (m.losses < lossmax) ? m.losses + 1 : lossmax;
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge clk) begin
        if (a_rst) va = 1'b1;
        if (b_rst) vb = 1'b1;
        ma = model_step(ma, a_rst, a_restart, a_locked, A_RST, A_TMO, A_STAB, A_MAXR, (1 << A_CW) - 1);
        mb = model_step(mb, b_rst, b_restart, b_locked, B_RST, B_TMO, B_STAB, B_MAXR, (1 << B_CW) - 1);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic compareDut(input string tag, input logic [2:0] st, input logic prst,
                              input logic rdy, input logic urst, input logic fl,
                              input logic [2:0] rc, input int loss, input mdl_t m);
        checkOutput({tag, "_state"}, int'(st), m.phase);
        checkOutput({tag, "_pll_rst"}, int'(prst), int'(m.phase == 0 || m.phase == 4));
        checkOutput({tag, "_ready"}, int'(rdy), int'(m.phase == 3));
        checkOutput({tag, "_user_rst"}, int'(urst), int'(m.phase != 3));
        checkOutput({tag, "_failed"}, int'(fl), int'(m.phase == 4));
        checkOutput({tag, "_retry_cnt"}, int'(rc), m.retries);
        checkOutput({tag, "_loss_cnt"}, loss, m.losses);
    endtask

    always @(negedge clk) begin
        if (va) compareDut("a", a_state, a_pll_rst, a_ready, a_user_rst, a_failed, a_retry, int'(a_loss), ma);
        if (vb) compareDut("b", b_state, b_pll_rst, b_ready, b_user_rst, b_failed, b_retry, int'(b_loss), mb);
    end

    function automatic bit probe(input int sel);
        case (sel)
            P_A_RST_LOW:   return a_pll_rst == 1'b0;
            P_A_READY:     return a_ready == 1'b1;
            P_A_NOT_READY: return a_ready == 1'b0;
            P_B_RST_LOW:   return b_pll_rst == 1'b0;
            P_B_READY:     return b_ready == 1'b1;
            P_B_NOT_READY: return b_ready == 1'b0;
            P_B_DEBOUNCE:  return b_state == 3'd2;
            default:       return 1'b0;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitFor(input int sel, input int budget, input string name, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (probe(sel)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) checkOutput({"timeout_", name}, 0, 1);
    endtask

    task automatic applyStimulus(input bit sel_b, input bit r, input bit rs, input bit lk);
        if (sel_b) begin
            b_rst = r; b_restart = rs; b_locked = lk;
        end else begin
            a_rst = r; a_restart = rs; a_locked = lk;
        end
    endtask

    task automatic checkResetValues(input bit sel_b, input string tag);
        if (sel_b) begin
            checkOutput({tag, "_rst_state"}, int'(b_state), 0);
            checkOutput({tag, "_rst_pll_rst"}, int'(b_pll_rst), 1);
            checkOutput({tag, "_rst_ready"}, int'(b_ready), 0);
            checkOutput({tag, "_rst_user_rst"}, int'(b_user_rst), 1);
            checkOutput({tag, "_rst_failed"}, int'(b_failed), 0);
            checkOutput({tag, "_rst_retry"}, int'(b_retry), 0);
            checkOutput({tag, "_rst_loss"}, int'(b_loss), 0);
        end else begin
            checkOutput({tag, "_rst_state"}, int'(a_state), 0);
            checkOutput({tag, "_rst_pll_rst"}, int'(a_pll_rst), 1);
            checkOutput({tag, "_rst_ready"}, int'(a_ready), 0);
            checkOutput({tag, "_rst_user_rst"}, int'(a_user_rst), 1);
            checkOutput({tag, "_rst_failed"}, int'(a_failed), 0);
            checkOutput({tag, "_rst_retry"}, int'(a_retry), 0);
            checkOutput({tag, "_rst_loss"}, int'(a_loss), 0);
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d, f, t, r, dd, rr, falls, fc;
        bit prev;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        idle(4);
        checkResetValues(1'b0, "a_pwrup");
        checkResetValues(1'b1, "b_pwrup");
        d = cyc;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] power-up with prompt lock");
        waitFor(P_A_RST_LOW, 200, "a_first_release", f);
        checkOutput("a_pll_rst_hold_len", f - d, 64);
        idle(100);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        t = cyc;
        waitFor(P_A_READY, 1500, "a_first_ready", r);
        checkOutput("a_ready_latency", r - t, 1027);
        checkOutput("a_retry_after_lock", int'(a_retry), 0);
        checkOutput("a_user_rst_when_ready", int'(a_user_rst), 0);

        $display("[TB] lock loss while ready");
        idle(20);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        dd = cyc;
        waitFor(P_A_NOT_READY, 10, "a_ready_drop", r);
        checkOutput("a_ready_drop_delay", r - dd, 3);
        checkOutput("a_loss_after_drop", int'(a_loss), 1);
        checkOutput("a_pll_rst_with_drop", int'(a_pll_rst), 1);
        waitFor(P_A_RST_LOW, 100, "a_second_release", f);
        checkOutput("a_second_hold_len", f - r, 64);
        idle(10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        t = cyc;
        waitFor(P_A_READY, 1500, "a_relock_ready", r);
        checkOutput("a_relock_latency", r - t, 1027);

        $display("[TB] restart coinciding with lock loss");
        idle(20);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        dd = cyc;
        idle(2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("a_restart_state", int'(a_state), 0);
        checkOutput("a_restart_loss_kept", int'(a_loss), 1);
        checkOutput("a_restart_ready", int'(a_ready), 0);
        checkOutput("a_restart_pll_rst", int'(a_pll_rst), 1);
        waitFor(P_A_RST_LOW, 100, "a_restart_release", f);
        checkOutput("a_restart_hold_len", f - (dd + 3), 64);

        $display("[TB] glitch during debounce");
        idle(5);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        idle(501);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        rr = cyc;
        waitFor(P_A_READY, 1500, "a_glitch_ready", r);
        checkOutput("a_glitch_latency", r - rr, 1027);
        checkOutput("a_glitch_retry", int'(a_retry), 0);

        $display("[TB] timeout and failure");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        d = cyc;
        falls = 0;
        fc = -1;
        prev = b_pll_rst;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (prev && !b_pll_rst) falls++;
            if (b_failed) begin
                fc = cyc;
                break;
            end
            prev = b_pll_rst;
        end
        checkOutput("b_pll_rst_pulses", falls, 3);
        checkOutput("b_failed_cycle", fc - d, 3192);
        checkOutput("b_failed_retry", int'(b_retry), 3);
        checkOutput("b_failed_state", int'(b_state), 4);
        checkOutput("b_failed_pll_rst", int'(b_pll_rst), 1);
        checkOutput("b_failed_user_rst", int'(b_user_rst), 1);
        idle(10);
        checkOutput("b_failed_sticky", int'(b_failed), 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("b_restart_state", int'(b_state), 0);
        checkOutput("b_restart_retry", int'(b_retry), 0);
        checkOutput("b_restart_failed", int'(b_failed), 0);
        checkOutput("b_restart_pll_rst", int'(b_pll_rst), 1);

        $display("[TB] loss counter saturation");
        waitFor(P_B_RST_LOW, 100, "b_sat_release", f);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
            waitFor(P_B_READY, 200, "b_sat_ready", r);
            idle(5);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            waitFor(P_B_NOT_READY, 10, "b_sat_drop", r);
            checkOutput("b_sat_loss", int'(b_loss), (i < 3) ? i : 3);
            waitFor(P_B_RST_LOW, 100, "b_sat_rerelease", f);
        end

        $display("[TB] reset during debounce");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        waitFor(P_B_DEBOUNCE, 50, "b_debounce", r);
        idle(3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        idle(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkResetValues(1'b1, "b_midrst");
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
